hier_skid_stage: RTL and testbench

Registered valid/ready pipeline stage with a two-entry skid buffer. It is placed at a hierarchy boundary, directly ahead of a chain of pass-through levels, to break the combinational path on both data and back-pressure. It accepts one word per cycle upstream and presents it registered downstream. It also counts completed output transfers and reports occupancy for lint and regression observation.

---
 rtl/hier_skid_stage.sv | 94 +++++++++
 tb/tb_hier_skid_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hier_skid_stage.sv
// hier_skid_stage: registered valid/ready stage with a two-entry skid buffer.
// Breaks both the data path and the back-pressure path at a hierarchy boundary.
// in_ready is a flop output, so out_ready never reaches it combinationally.
// The FSM state is visible directly on the occupancy port (0, 1 or 2 words held).
//
// Handshake semantics: a word moves only on a cycle where valid && ready are
// both high at the rising edge. A producer holding valid must keep data stable
// until ready is seen. While out_valid && !out_ready, out_valid and out_data
// are held stable. in_valid without in_ready is ignored and in_data is not
// sampled.
module hier_skid_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             take;

    assign accept     = in_valid && in_ready_q;
    assign take       = (state != EMPTY) && out_ready;

    assign in_ready   = in_ready_q;
    assign out_valid  = (state != EMPTY);
    assign out_data   = main_q;
    assign occupancy  = state;
    assign xfer_count = cnt_q;

    // Next-state decode from the two handshakes; FULL never accepts because in_ready is low there.
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: if (accept) next_state = ONE;
            ONE: begin
                if (accept && !take)      next_state = FULL;
                else if (!accept && take) next_state = EMPTY;
                else                      next_state = ONE;
            end
            FULL:    if (take) next_state = ONE;
            default: next_state = EMPTY;
        endcase
    end

    // State, data registers, registered in_ready and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state != FULL);
            if (take) cnt_q <= cnt_q + CNT_ONE;
            case (state)
                EMPTY: if (accept) main_q <= in_data;
                ONE: begin
                    // Simultaneous accept and take replaces main in place;
                    // accept alone parks the new word behind main.
                    if (accept && take) main_q <= in_data;
                    else if (accept)    skid_q <= in_data;
                end
                FULL: if (take) main_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hier_skid_stage.sv
// Bench for hier_skid_stage: queue-based reference model, per-cycle compare,
// directed literal checks, and a randomized phase.
module tb_hier_skid_stage;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         in_ready,  in_ready2;
    logic         out_valid, out_valid2;
    logic [W-1:0] out_data,  out_data2;
    logic [1:0]   occupancy, occupancy2;
    logic [15:0]  xfer_count;
    logic [1:0]   xfer_count2;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] exp_q[$];
    logic         m_in_ready;
    int unsigned  m_count;

    hier_skid_stage #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .xfer_count(xfer_count)
    );

    hier_skid_stage #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .xfer_count(xfer_count2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: FIFO of at most two words, in_ready from post-edge fill
    initial begin
        exp_q.delete();
        m_in_ready = 1'b0;
        m_count    = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_in_ready = 1'b0;
                m_count    = 0;
            end else begin
                logic         acc;
                logic         tk;
                logic [W-1:0] d;
                acc = in_valid && m_in_ready;
                tk  = (exp_q.size() != 0) && out_ready;
                d   = in_data;
                if (tk) begin
                    void'(exp_q.pop_front());
                    m_count++;
                end
                if (acc) exp_q.push_back(d);
                m_in_ready = (exp_q.size() != 2);
            end
        end
    end

    // per-cycle compare of both instances against the model
    always @(negedge clk) begin
        chk("in_ready",    {31'd0, in_ready},    {31'd0, m_in_ready});
        chk("out_valid",   {31'd0, out_valid},   {31'd0, exp_q.size() != 0});
        chk("occupancy",   {30'd0, occupancy},   exp_q.size());
        chk("xfer_count",  {16'd0, xfer_count},  m_count % 65536);
        chk("in_ready2",   {31'd0, in_ready2},   {31'd0, m_in_ready});
        chk("occupancy2",  {30'd0, occupancy2},  exp_q.size());
        chk("xfer_count2", {30'd0, xfer_count2}, m_count % 4);
        if (exp_q.size() != 0) begin
            chk("out_data",  {24'd0, out_data},  {24'd0, exp_q[0]});
            chk("out_data2", {24'd0, out_data2}, {24'd0, exp_q[0]});
        end
    end

    // driver: set inputs, let one rising edge pass, settle 1 time unit
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // reset release
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready",   {31'd0, in_ready},   32'd0);
        chk("rst out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst occupancy",  {30'd0, occupancy},  32'd0);
        chk("rst xfer_count", {16'd0, xfer_count}, 32'd0);
        chk("rst out_data",   {24'd0, out_data},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release in_ready", {31'd0, in_ready}, 32'd1);

        // streaming with out_ready high
        step(1'b1, 8'h11, 1'b1);
        chk("s1 data", {24'd0, out_data}, 32'h11);
        chk("s1 occ",  {30'd0, occupancy}, 32'd1);
        step(1'b1, 8'h22, 1'b1);
        chk("s2 data", {24'd0, out_data}, 32'h22);
        chk("s2 occ",  {30'd0, occupancy}, 32'd1);
        step(1'b1, 8'h33, 1'b1);
        chk("s3 data", {24'd0, out_data}, 32'h33);
        step(1'b0, 8'h00, 1'b1);
        chk("s cnt",   {16'd0, xfer_count}, 32'd3);
        chk("s occ0",  {30'd0, occupancy}, 32'd0);

        // stall, ignored input while full, drain
        step(1'b1, 8'hA1, 1'b0);
        chk("st1 data", {24'd0, out_data}, 32'hA1);
        step(1'b1, 8'hA2, 1'b0);
        chk("st2 occ",   {30'd0, occupancy}, 32'd2);
        chk("st2 ready", {31'd0, in_ready}, 32'd0);
        chk("st2 data",  {24'd0, out_data}, 32'hA1);
        step(1'b1, 8'hFF, 1'b0);
        chk("st3 occ",   {30'd0, occupancy}, 32'd2);
        chk("st3 data",  {24'd0, out_data}, 32'hA1);
        step(1'b0, 8'hFF, 1'b1);
        chk("st4 data",  {24'd0, out_data}, 32'hA2);
        chk("st4 ready", {31'd0, in_ready}, 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("st5 occ",   {30'd0, occupancy}, 32'd0);
        chk("st5 cnt",   {16'd0, xfer_count}, 32'd5);

        // mid-operation reset while full
        step(1'b1, 8'hB1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        chk("mr full", {30'd0, occupancy}, 32'd2);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mr occ",   {30'd0, occupancy},  32'd0);
        chk("mr valid", {31'd0, out_valid},  32'd0);
        chk("mr ready", {31'd0, in_ready},   32'd0);
        chk("mr data",  {24'd0, out_data},   32'd0);
        chk("mr cnt",   {16'd0, xfer_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'hC1, 1'b0);
        chk("mr first", {24'd0, out_data}, 32'hC1);

        // counter wrap on the 2-bit instance
        step(1'b1, 8'hC2, 1'b1);
        chk("wrap 1", {30'd0, xfer_count2}, 32'd1);
        step(1'b1, 8'hC3, 1'b1);
        chk("wrap 2", {30'd0, xfer_count2}, 32'd2);
        step(1'b1, 8'hC4, 1'b1);
        chk("wrap 3", {30'd0, xfer_count2}, 32'd3);
        step(1'b1, 8'hC5, 1'b1);
        chk("wrap 0", {30'd0, xfer_count2}, 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("wrap 1b", {30'd0, xfer_count2}, 32'd1);

        // randomized traffic, occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            step(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) != 0));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
